// File: rtl/ifetch32_if.sv
// Fetch-to-decoder/imem bundle for ifetch32; IFETCH_PERF_EN adds the perf counter outputs.
interface ifetch32_if;
  logic        stall;
  logic        ib_in;
  logic        bl_in;
  logic [31:0] bv_in;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] iout;
  logic [31:0] pc_out;
  logic        ispb_out;
  logic        link_we;
  logic [31:0] link_val;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] squash_cnt;
`endif

  modport master (
    input  stall, ib_in, bl_in, bv_in, imem_rdata,
    output imem_addr, iout, pc_out, ispb_out, link_we, link_val
`ifdef IFETCH_PERF_EN
    , output fetch_cnt, squash_cnt
`endif
  );

  modport slave (
    output stall, ib_in, bl_in, bv_in, imem_rdata,
    input  imem_addr, iout, pc_out, ispb_out, link_we, link_val
`ifdef IFETCH_PERF_EN
    , input fetch_cnt, squash_cnt
`endif
  );
endinterface

// File: rtl/ifetch32.sv
// Instruction fetch stage: owns the PC, drives a sync-read imem and redirects on decoder branches.
// Optional perf counters (fetch_cnt, squash_cnt) enabled by `define IFETCH_PERF_EN.
module ifetch32 #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic       clk,
  input  logic       reset,
  ifetch32_if.master bus
);

  localparam int unsigned PcW = 32;
  localparam logic [1:0] S_BOOT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_SQUASH = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [PcW-1:0] fetch_pc_q, fetch_pc_d;
  logic [PcW-1:0] pc_out_q, pc_out_d;
  logic [PcW-1:0] target_c;
  logic           link_we_c;
  logic           squash_enter_c;

  // Branch target is relative to the branch's own address plus 8, forced word aligned
  assign target_c = (pc_out_q + PcW'(8) + bus.bv_in) & ~PcW'(3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      pc_out_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_out_q   <= pc_out_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    pc_out_d       = pc_out_q;
    link_we_c      = 1'b0;
    squash_enter_c = 1'b0;
    if (!bus.stall) begin
      case (state_q)
        S_BOOT, S_SQUASH: begin
          pc_out_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PcW'(4);
          state_d    = S_RUN;
        end
        S_RUN: begin
          pc_out_d = fetch_pc_q;
          if (bus.ib_in) begin
            fetch_pc_d     = target_c;
            state_d        = S_SQUASH;
            link_we_c      = bus.bl_in;
            squash_enter_c = 1'b1;
          end else begin
            fetch_pc_d = fetch_pc_q + PcW'(4);
          end
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  // Stalled: re-read the word already on iout so the decoder sees a stable instruction
  assign bus.imem_addr = bus.stall ? pc_out_q : fetch_pc_q;
  assign bus.iout      = (state_q == S_BOOT) ? '0 : bus.imem_rdata;
  assign bus.pc_out    = pc_out_q;
  assign bus.ispb_out  = (state_q == S_SQUASH);
  assign bus.link_we   = link_we_c;
  assign bus.link_val  = pc_out_q + PcW'(4);

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, squash_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (!bus.stall && (state_q != S_BOOT)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (squash_enter_c)                    squash_cnt_q <= squash_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt  = fetch_cnt_q;
  assign bus.squash_cnt = squash_cnt_q;
`else
  logic unused_c;
  assign unused_c = squash_enter_c;
`endif

endmodule

// File: tb/tb_ifetch32.sv
// Directed bench for ifetch32 with an address-equals-data sync-read imem model.
module tb_ifetch32;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  ifetch32_if bus ();

  ifetch32 #(.RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory: data word equals its address
  always @(posedge clk) bus.imem_rdata <= bus.imem_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.ib_in = 1'b0;
    bus.bl_in = 1'b0;
    bus.bv_in = 32'h0;

    // 1: reset release and sequential fetch
    apply_reset();
    check("boot_iout", bus.iout, 32'h0);
    check("boot_pc", bus.pc_out, 32'h0);
    check("boot_ispb", 32'(bus.ispb_out), 32'h0);
    check("boot_link_we", 32'(bus.link_we), 32'h0);
    check("boot_link_val", bus.link_val, 32'h4);
    tick();
    check("run0_pc", bus.pc_out, 32'h0);
    check("run0_iout", bus.iout, 32'h0);
    tick();
    check("run1_pc", bus.pc_out, 32'h4);
    check("run1_iout", bus.iout, 32'h4);
    tick();
    check("run2_pc", bus.pc_out, 32'h8);
    check("run2_iout", bus.iout, 32'h8);
    check("run2_ispb", 32'(bus.ispb_out), 32'h0);
    tick();
    tick();
    check("pre_br_pc", bus.pc_out, 32'h10);

    // 2: taken branch, no link; ib_in during squash is ignored
    bus.ib_in = 1'b1;
    bus.bv_in = 32'h20;
    #1;
    check("br_no_link", 32'(bus.link_we), 32'h0);
    tick();
    bus.bv_in = 32'h100;
    check("sq_pc", bus.pc_out, 32'h14);
    check("sq_ispb", 32'(bus.ispb_out), 32'h1);
    check("sq_iout", bus.iout, 32'h14);
    tick();
    bus.ib_in = 1'b0;
    bus.bv_in = 32'h0;
    check("tgt_pc", bus.pc_out, 32'h38);
    check("tgt_iout", bus.iout, 32'h38);
    check("tgt_ispb", 32'(bus.ispb_out), 32'h0);
    tick();
    check("tgt4_pc", bus.pc_out, 32'h3C);
    tick();
    check("pre_bl_pc", bus.pc_out, 32'h40);

    // 3: branch-and-link to self
    bus.ib_in = 1'b1;
    bus.bl_in = 1'b1;
    bus.bv_in = 32'hFFFF_FFF8;
    #1;
    check("bl_link_we", 32'(bus.link_we), 32'h1);
    check("bl_link_val", bus.link_val, 32'h44);
    tick();
    bus.ib_in = 1'b0;
    bus.bl_in = 1'b0;
    bus.bv_in = 32'h0;
    check("bl_sq_pc", bus.pc_out, 32'h44);
    check("bl_sq_ispb", 32'(bus.ispb_out), 32'h1);
    check("bl_sq_link_we", 32'(bus.link_we), 32'h0);
    tick();
    check("self_pc", bus.pc_out, 32'h40);
    check("self_ispb", 32'(bus.ispb_out), 32'h0);
    tick();
    check("self4_pc", bus.pc_out, 32'h44);

    // 4: stall holds the stage; branch inputs ignored while stalled
    apply_reset();
    tick();
    tick();
    tick();
    check("pre_stall_pc", bus.pc_out, 32'h8);
    bus.stall = 1'b1;
    bus.ib_in = 1'b1;
    bus.bl_in = 1'b1;
    #1;
    check("stall_addr", bus.imem_addr, 32'h8);
    check("stall_link_we", 32'(bus.link_we), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.pc_out, 32'h8);
      check("stall_iout", bus.iout, 32'h8);
      check("stall_addr_h", bus.imem_addr, 32'h8);
    end
    bus.stall = 1'b0;
    bus.ib_in = 1'b0;
    bus.bl_in = 1'b0;
    #1;
    check("unstall_addr", bus.imem_addr, 32'hC);
    tick();
    check("unstall_pc", bus.pc_out, 32'hC);
    check("unstall_iout", bus.iout, 32'hC);
    check("unstall_ispb", 32'(bus.ispb_out), 32'h0);

    // 5: async reset in the middle of a squash cycle
    bus.ib_in = 1'b1;
    tick();
    bus.ib_in = 1'b0;
    check("pre_rst_ispb", 32'(bus.ispb_out), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_pc", bus.pc_out, 32'h0);
    check("arst_ispb", 32'(bus.ispb_out), 32'h0);
    check("arst_iout", bus.iout, 32'h0);
    check("arst_addr", bus.imem_addr, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("rec_pc", bus.pc_out, 32'h0);
    check("rec_ispb", 32'(bus.ispb_out), 32'h0);

    // Target low bits forced to zero
    tick();
    tick();
    tick();
    check("pre_mask_pc", bus.pc_out, 32'hC);
    bus.ib_in = 1'b1;
    bus.bv_in = 32'hFFFF_FFEF;
    tick();
    bus.ib_in = 1'b0;
    check("mask_sq_pc", bus.pc_out, 32'h10);
    tick();
    check("mask_tgt_pc", bus.pc_out, 32'h0);
    check("mask_tgt_iout", bus.iout, 32'h0);

    // Modulo-2^32 wrap through the top of the address space
    bus.ib_in = 1'b1;
    bus.bv_in = 32'hFFFF_FFF0;
    tick();
    bus.ib_in = 1'b0;
    bus.bv_in = 32'h0;
    check("wrap_sq_pc", bus.pc_out, 32'h4);
    tick();
    check("wrap_tgt_pc", bus.pc_out, 32'hFFFF_FFF8);
    tick();
    check("wrap_top_pc", bus.pc_out, 32'hFFFF_FFFC);
    check("wrap_top_link", bus.link_val, 32'h0);
    tick();
    check("wrap_zero_pc", bus.pc_out, 32'h0);
    check("wrap_zero_iout", bus.iout, 32'h0);

`ifdef IFETCH_PERF_EN
    // 6: 10 issue cycles with one taken branch and 2 stall cycles
    apply_reset();
    check("perf_rst_fetch", bus.fetch_cnt, 32'h0);
    check("perf_rst_squash", bus.squash_cnt, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) tick();
    bus.ib_in = 1'b1;
    bus.bv_in = 32'h0;
    tick();
    bus.ib_in = 1'b0;
    tick();
    bus.stall = 1'b1;
    tick();
    tick();
    bus.stall = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("perf_fetch", bus.fetch_cnt, 32'd10);
    check("perf_squash", bus.squash_cnt, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
